// File: rtl/fir_tap_feeder.sv
// fir_tap_feeder: rate-paced valid/ready sample intake feeding an 8-deep tap delay line.
// Optional macro FIR_FEEDER_PRIME_GATE_EN holds off o_valid until all eight taps are loaded.
module fir_tap_feeder #(
    parameter int NB_DATA  = 8,
    parameter int RATE_DIV = 4
) (
    input  logic                      i_clk_G,
    input  logic                      i_rst_n,
    input  logic                      i_flush,
    input  logic signed [NB_DATA-1:0] i_data,
    input  logic                      i_valid,
    output logic                      o_ready,
    output logic signed [NB_DATA-1:0] o_x0,
    output logic signed [NB_DATA-1:0] o_x1,
    output logic signed [NB_DATA-1:0] o_x2,
    output logic signed [NB_DATA-1:0] o_x3,
    output logic signed [NB_DATA-1:0] o_x4,
    output logic signed [NB_DATA-1:0] o_x5,
    output logic signed [NB_DATA-1:0] o_x6,
    output logic signed [NB_DATA-1:0] o_x7,
    output logic                      o_valid,
    output logic                      o_underrun,
    output logic [3:0]                o_fill
);
    localparam int PW = RATE_DIV > 1 ? $clog2(RATE_DIV) : 1;

    logic [PW-1:0]             phase;
    logic signed [NB_DATA-1:0] taps [8];
    logic                      accept;
    logic                      underrun;
    logic                      strobe;

    assign o_ready  = phase == '0;
    assign accept   = i_valid & o_ready & ~i_flush;
    assign underrun = ~i_valid & o_ready & ~i_flush;
`ifdef FIR_FEEDER_PRIME_GATE_EN
    // the eighth accept is the one that moves o_fill from 7 to 8
    assign strobe = accept & (o_fill >= 4'd7);
`else
    assign strobe = accept;
`endif

    always_ff @(posedge i_clk_G or negedge i_rst_n) begin
        if (!i_rst_n) begin
            phase      <= '0;
            o_fill     <= '0;
            o_valid    <= 1'b0;
            o_underrun <= 1'b0;
            for (int k = 0; k < 8; k++) taps[k] <= '0;
        end else begin
            phase      <= (i_flush || phase == PW'(RATE_DIV - 1)) ? '0 : phase + 1'b1;
            o_valid    <= strobe;
            o_underrun <= underrun;
            if (i_flush) begin
                o_fill <= '0;
                for (int k = 0; k < 8; k++) taps[k] <= '0;
            end else if (accept) begin
                o_fill  <= o_fill + {3'b000, o_fill != 4'd8};
                taps[0] <= i_data;
                for (int k = 1; k < 8; k++) taps[k] <= taps[k-1];
            end
        end
    end

    assign o_x0 = taps[0];
    assign o_x1 = taps[1];
    assign o_x2 = taps[2];
    assign o_x3 = taps[3];
    assign o_x4 = taps[4];
    assign o_x5 = taps[5];
    assign o_x6 = taps[6];
    assign o_x7 = taps[7];
endmodule

// File: tb/tb_fir_tap_feeder.sv
// tb_fir_tap_feeder: three feeders (RATE_DIV 4, 2, 1) share one random stream; each is
// scored against a sample-history model, with expected tap sets queued per accepted sample.
module tb_fir_tap_feeder;
    logic              clk = 1'b0;
    logic              rst_n;
    logic              i_flush;
    logic              i_valid;
    logic signed [7:0] i_data;
    int                n_chk = 0;
    int                n_fail = 0;

`ifdef FIR_FEEDER_PRIME_GATE_EN
    localparam bit GATE = 1'b1;
`else
    localparam bit GATE = 1'b0;
`endif

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    for (genvar g = 0; g < 3; g++) begin : gen_r
        localparam int R = g == 0 ? 4 : (g == 1 ? 2 : 1);
        logic              ready, valid, underrun;
        logic [3:0]        fill;
        logic signed [7:0] x0, x1, x2, x3, x4, x5, x6, x7;
        logic signed [7:0] hist[$];
        logic [63:0]       expq[$];
        int                cnt = 0;
        logic              ev = 1'b0;
        logic              eu = 1'b0;

        fir_tap_feeder #(.NB_DATA(8), .RATE_DIV(R)) dut (
            .i_clk_G(clk), .i_rst_n(rst_n), .i_flush(i_flush), .i_data(i_data),
            .i_valid(i_valid), .o_ready(ready), .o_x0(x0), .o_x1(x1), .o_x2(x2),
            .o_x3(x3), .o_x4(x4), .o_x5(x5), .o_x6(x6), .o_x7(x7),
            .o_valid(valid), .o_underrun(underrun), .o_fill(fill)
        );

        // reference: the newest eight accepted samples, slots every R cycles since reset/flush
        initial forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                hist.delete();
                expq.delete();
                cnt = 0;
                ev  = 1'b0;
                eu  = 1'b0;
            end else begin
                logic rdy;
                logic [63:0] e;
                rdy = (cnt % R) == 0;
                ev  = 1'b0;
                eu  = rdy && !i_valid && !i_flush;
                if (i_flush) begin
                    hist.delete();
                    cnt = 0;
                end else begin
                    if (rdy && i_valid) begin
                        hist.push_front(i_data);
                        if (hist.size() > 8) void'(hist.pop_back());
                        ev = GATE ? hist.size() == 8 : 1'b1;
                        e  = '0;
                        for (int k = 0; k < hist.size(); k++) e[k*8 +: 8] = hist[k];
                        if (ev) expq.push_back(e);
                    end
                    cnt++;
                end
            end
        end

        initial forever begin
            @(negedge clk);
            chk($sformatf("R%0d o_valid", R), 64'(valid), 64'(ev));
            chk($sformatf("R%0d o_underrun", R), 64'(underrun), 64'(eu));
            chk($sformatf("R%0d o_ready", R), 64'(ready), 64'((cnt % R) == 0));
            chk($sformatf("R%0d o_fill", R), 64'(fill), 64'(hist.size()));
            if (valid) begin
                if (expq.size() == 0) chk($sformatf("R%0d unexpected o_valid", R), 64'(1), 64'(0));
                else chk($sformatf("R%0d taps", R), {x7, x6, x5, x4, x3, x2, x1, x0}, expq.pop_front());
            end
        end

        initial forever begin
            @(negedge rst_n);
            #1;
            chk($sformatf("R%0d async reset taps", R), {x7, x6, x5, x4, x3, x2, x1, x0}, 64'(0));
            chk($sformatf("R%0d async reset fill", R), 64'(fill), 64'(0));
            chk($sformatf("R%0d async reset valid", R), 64'(valid), 64'(0));
        end
    end

    task automatic hold(input logic [7:0] d, input logic v, input logic f, input int n);
        i_data  = d;
        i_valid = v;
        i_flush = f;
        repeat (n) @(negedge clk);
    endtask

    task automatic rand_run(input int n);
        repeat (n) hold(8'($urandom), $urandom_range(0, 9) < 7, $urandom_range(0, 31) == 0, 1);
    endtask

    initial begin
        rst_n = 1'b0;
        hold(8'h00, 1'b0, 1'b0, 3);
        rst_n = 1'b1;
        for (int i = 1; i <= 8; i++) hold(8'(i), 1'b1, 1'b0, 4);
        hold(8'h80, 1'b1, 1'b0, 4);
        hold(8'h7F, 1'b1, 1'b0, 4);
        hold(8'hFF, 1'b1, 1'b0, 4);
        hold(8'h55, 1'b0, 1'b0, 4);
        hold(8'h11, 1'b1, 1'b0, 4);
        hold(8'h22, 1'b1, 1'b1, 1);
        hold(8'h33, 1'b1, 1'b0, 4);
        for (int i = 0; i <= 20; i++) hold(8'(i), 1'b1, 1'b0, 1);
        rand_run(300);
        hold(8'h5A, 1'b1, 1'b0, 4);
        #7 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        rand_run(150);
        hold(8'h00, 1'b0, 1'b0, 4);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
